// File: rtl/npu_pkg.sv
// Shared widths, sizes and the stage state type for the NPU post-conv datapath.
package npu_pkg;

    localparam int ACC_W      = 18;
    localparam int PIX_W      = 8;
    localparam int N_CONV_OUT = 30;
    localparam int N_POOL     = 15;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        STREAM
    } state_t;

endpackage

// File: rtl/pool_quant_lane.sv
// One output pixel: ReLU on a pair of conv results, max-pool, requantising shift, clamp to 8 bits.
module pool_quant_lane
    import npu_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic [PIX_W-1:0]        pix
);

    logic [ACC_W-2:0] relu_a;
    logic [ACC_W-2:0] relu_b;
    logic [ACC_W-2:0] pooled;
    logic [ACC_W-2:0] shifted;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        relu_a  = a[ACC_W-1] ? '0 : a[ACC_W-2:0];
        relu_b  = b[ACC_W-1] ? '0 : b[ACC_W-2:0];
        pooled  = (relu_a > relu_b) ? relu_a : relu_b;
        shifted = pooled >> SHIFT;
        pix     = (shifted > (ACC_W-1)'(255)) ? '1 : shifted[PIX_W-1:0];
    end

endmodule

// File: rtl/relu_pool_stage.sv
// Captures one conv row, then streams N_IN/2 pooled, requantised pixels over a valid/ready port.
module relu_pool_stage
    import npu_pkg::*;
#(
    parameter int SHIFT = 4,
    parameter int N_IN  = N_CONV_OUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    conv_done,
    input  logic signed [ACC_W-1:0] conv_result [0:N_IN-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIX_W-1:0]        out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    drop_err
);

    localparam int NP = N_IN / 2;
    localparam int IW = (NP > 1) ? $clog2(NP) : 1;
    localparam int BW = $clog2(N_IN);

    state_t                  state;
    logic [IW-1:0]           idx;
    logic signed [ACC_W-1:0] row_buf [0:N_IN-1];

    int                      sel;
    logic [BW-1:0]           lo_sel;
    logic [BW-1:0]           hi_sel;
    logic [PIX_W-1:0]        pix;

    // The lane always computes the pixel that will be registered next: 0 in PREP, idx+1 in STREAM.
    always_comb begin
        sel = 0;
        if (state == STREAM && idx != IW'(NP - 1)) begin
            sel = int'(idx) + 1;
        end
        lo_sel = BW'(2 * sel);
        hi_sel = BW'(2 * sel + 1);
    end

    pool_quant_lane #(
        .SHIFT(SHIFT)
    ) u_lane (
        .a  (row_buf[lo_sel]),
        .b  (row_buf[hi_sel]),
        .pix(pix)
    );

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            drop_err  <= 1'b0;
            // NOTE: the row buffer is cleared too, so a reset never leaves a stale row behind.
            for (int k = 0; k < N_IN; k++) begin
                row_buf[k] <= '0;
            end
        end else begin
            if (conv_done && state != IDLE) begin
                drop_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (conv_done) begin
                        for (int k = 0; k < N_IN; k++) begin
                            row_buf[k] <= conv_result[k];
                        end
                        idx   <= '0;
                        state <= PREP;
                    end
                end
                PREP: begin
                    out_data  <= pix;
                    out_valid <= 1'b1;
                    out_last  <= (NP == 1);
                    idx       <= '0;
                    state     <= STREAM;
                end
                STREAM: begin
                    // out_valid is always 1 in this state, so out_ready alone marks a transfer.
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            idx      <= idx + IW'(1);
                            out_data <= pix;
                            out_last <= (idx == IW'(NP - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_pool_stage.sv
// Self-checking bench: random rows against a plain-arithmetic pooling model, plus directed corner cases.
module tb_relu_pool_stage;

    localparam int SHIFT = 4;
    localparam int N_IN  = 30;
    localparam int NP    = N_IN / 2;

    logic clk = 1'b0;
    logic rst;
    logic conv_done;
    logic signed [17:0] conv_result [0:N_IN-1];
    logic out_valid;
    logic out_ready;
    logic [7:0] out_data;
    logic out_last;
    logic busy;
    logic drop_err;

    logic signed [17:0] row_v [0:N_IN-1];
    int exp_pix [0:NP-1];
    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] got_d [$];
    logic       got_l [$];
    logic [7:0] stall_d [$];
    logic       stall_l [$];
    logic       stall_v [$];
    logic       ev_drop_err, ev_valid, ev_busy;
    logic [7:0] ev_data;
    bit         timed_out;

    relu_pool_stage #(
        .SHIFT(SHIFT),
        .N_IN (N_IN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .conv_done  (conv_done),
        .conv_result(conv_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: relu each of the pair, take the larger, divide by 2^SHIFT, clamp at 255.
    function automatic int model_pix(int i);
        int a = int'(row_v[2*i]);
        int b = int'(row_v[2*i+1]);
        int m;
        if (a < 0) a = 0;
        if (b < 0) b = 0;
        m = (a > b) ? a : b;
        m = m / (1 << SHIFT);
        return (m > 255) ? 255 : m;
    endfunction

    task automatic fill_random_row();
        for (int k = 0; k < N_IN; k++) begin
            if ($urandom_range(0, 1) == 1) row_v[k] = 18'($urandom);
            else row_v[k] = 18'(int'($urandom_range(0, 8191)) - 4096);
        end
    endtask

    task automatic pulse_conv();
        for (int k = 0; k < N_IN; k++) conv_result[k] = row_v[k];
        for (int i = 0; i < NP; i++) exp_pix[i] = model_pix(i);
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
    endtask

    // Accepts pixels until out_last transfers. ev_kind: 0 none, 1 stall 3 cycles, 2 extra conv_done, 3 reset.
    task automatic collect_row(input int ready_mode, input int ev_idx, input int ev_kind);
        int  cycles = 0;
        bit  done = 0;
        bit  fired = 0;
        bit  rdy;
        got_d.delete(); got_l.delete();
        stall_d.delete(); stall_l.delete(); stall_v.delete();
        timed_out = 0;
        while (!done) begin
            cycles++;
            if (cycles > 2000) begin
                timed_out = 1;
                break;
            end
            if (!fired && ev_kind != 0 && out_valid && got_d.size() == ev_idx) begin
                fired = 1;
                if (ev_kind == 1) begin
                    out_ready = 1'b0;
                    for (int s = 0; s < 3; s++) begin
                        tick();
                        stall_d.push_back(out_data);
                        stall_l.push_back(out_last);
                        stall_v.push_back(out_valid);
                    end
                    continue;
                end else if (ev_kind == 2) begin
                    out_ready = 1'b0;
                    for (int k = 0; k < N_IN; k++) conv_result[k] = 18'($urandom);
                    conv_done = 1'b1;
                    tick();
                    conv_done = 1'b0;
                    ev_drop_err = drop_err;
                    continue;
                end else begin
                    out_ready = 1'b0;
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    ev_valid = out_valid;
                    ev_busy  = busy;
                    ev_data  = out_data;
                    ev_drop_err = drop_err;
                    done = 1;
                    continue;
                end
            end
            rdy = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
            out_ready = rdy;
            if (out_valid && rdy) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                if (out_last) done = 1;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; conv_done = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < N_IN; k++) conv_result[k] = 18'($urandom);
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", out_last); end
        n_cmp++; if (out_data !== 8'd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", out_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL reset_drop_err: got %b want 0", drop_err); end
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL idle_ready: busy %b valid %b want 0 0", busy, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_directed_row();
        for (int k = 0; k < N_IN; k++) row_v[k] = '0;
        row_v[0] = 18'sd100; row_v[1] = -18'sd50;
        pulse_conv();
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL prep_timing: valid %b busy %b want 0 1", out_valid, busy); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'd6) begin n_err++; $display("FAIL first_pixel: valid %b data %0d want 1 6", out_valid, out_data); end
        collect_row(0, -1, 0);
        n_cmp++; if (timed_out || got_d.size() != NP) begin n_err++; $display("FAIL row1_count: got %0d want %0d", got_d.size(), NP); end
        for (int i = 0; i < NP && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== ((i == 0) ? 8'd6 : 8'd0) || got_l[i] !== (i == NP - 1)) begin
                n_err++; $display("FAIL row1_pix%0d: got %0d last %b want %0d", i, got_d[i], got_l[i], (i == 0) ? 6 : 0);
            end
        end
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL row1_end: busy %b valid %b want 0 0", busy, out_valid); end

        row_v[2] = -18'sd1;      row_v[3] = -18'sd200;
        row_v[4] = 18'sd5000;    row_v[5] = 18'sd4096;
        row_v[6] = 18'sd131071;  row_v[7] = 18'sd0;
        pulse_conv();
        collect_row(0, -1, 0);
        n_cmp++; if (timed_out || got_d.size() != NP) begin n_err++; $display("FAIL row2_count: got %0d want %0d", got_d.size(), NP); end
        if (got_d.size() >= 4) begin
            n_cmp++; if (got_d[1] !== 8'd0) begin n_err++; $display("FAIL relu_neg: got %0d want 0", got_d[1]); end
            n_cmp++; if (got_d[2] !== 8'd255) begin n_err++; $display("FAIL sat_5000: got %0d want 255", got_d[2]); end
            n_cmp++; if (got_d[3] !== 8'd255) begin n_err++; $display("FAIL sat_max: got %0d want 255", got_d[3]); end
        end
    endtask

    task automatic test_random_rows();
        for (int r = 0; r < 8; r++) begin
            fill_random_row();
            pulse_conv();
            collect_row(1, -1, 0);
            n_cmp++; if (timed_out || got_d.size() != NP) begin n_err++; $display("FAIL rand%0d_count: got %0d want %0d", r, got_d.size(), NP); end
            for (int i = 0; i < NP && i < got_d.size(); i++) begin
                n_cmp++;
                if (got_d[i] !== exp_pix[i][7:0] || got_l[i] !== (i == NP - 1)) begin
                    n_err++; $display("FAIL rand%0d_pix%0d: got %0d last %b want %0d", r, i, got_d[i], got_l[i], exp_pix[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        fill_random_row();
        pulse_conv();
        collect_row(0, 7, 1);
        n_cmp++; if (stall_d.size() != 3) begin n_err++; $display("FAIL stall_count: got %0d want 3", stall_d.size()); end
        for (int s = 0; s < stall_d.size(); s++) begin
            n_cmp++;
            if (stall_d[s] !== exp_pix[7][7:0] || stall_l[s] !== 1'b0 || stall_v[s] !== 1'b1) begin
                n_err++; $display("FAIL stall_hold%0d: data %0d last %b valid %b want %0d 0 1", s, stall_d[s], stall_l[s], stall_v[s], exp_pix[7]);
            end
        end
        n_cmp++; if (timed_out || got_d.size() != NP) begin n_err++; $display("FAIL stall_transfers: got %0d want %0d", got_d.size(), NP); end
        for (int i = 0; i < NP && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_pix[i][7:0] || got_l[i] !== (i == NP - 1)) begin
                n_err++; $display("FAIL stall_pix%0d: got %0d last %b want %0d", i, got_d[i], got_l[i], exp_pix[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        fill_random_row();
        pulse_conv();
        collect_row(0, -1, 0);
        n_cmp++; if (timed_out || got_d.size() != NP) begin n_err++; $display("FAIL b2b_a_count: got %0d want %0d", got_d.size(), NP); end
        fill_random_row();
        pulse_conv();
        n_cmp++; if (drop_err !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_accept: drop_err %b busy %b valid %b want 0 1 0", drop_err, busy, out_valid);
        end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_pix[0][7:0]) begin
            n_err++; $display("FAIL b2b_first: valid %b data %0d want 1 %0d", out_valid, out_data, exp_pix[0]);
        end
        collect_row(0, -1, 0);
        n_cmp++; if (timed_out || got_d.size() != NP) begin n_err++; $display("FAIL b2b_b_count: got %0d want %0d", got_d.size(), NP); end
        for (int i = 0; i < NP && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_pix[i][7:0] || got_l[i] !== (i == NP - 1)) begin
                n_err++; $display("FAIL b2b_pix%0d: got %0d last %b want %0d", i, got_d[i], got_l[i], exp_pix[i]);
            end
        end
        n_cmp++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL b2b_drop_err: got %b want 0", drop_err); end
    endtask

    task automatic test_drop();
        n_cmp++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL drop_pre: got %b want 0", drop_err); end
        fill_random_row();
        pulse_conv();
        collect_row(0, 5, 2);
        n_cmp++; if (ev_drop_err !== 1'b1) begin n_err++; $display("FAIL drop_set: got %b want 1", ev_drop_err); end
        n_cmp++; if (timed_out || got_d.size() != NP) begin n_err++; $display("FAIL drop_count: got %0d want %0d", got_d.size(), NP); end
        for (int i = 0; i < NP && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_pix[i][7:0]) begin
                n_err++; $display("FAIL drop_pix%0d: got %0d want %0d", i, got_d[i], exp_pix[i]);
            end
        end
        fill_random_row();
        pulse_conv();
        collect_row(1, -1, 0);
        n_cmp++; if (timed_out || got_d.size() != NP) begin n_err++; $display("FAIL drop_next_count: got %0d want %0d", got_d.size(), NP); end
        n_cmp++; if (drop_err !== 1'b1) begin n_err++; $display("FAIL drop_sticky: got %b want 1", drop_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL drop_clear: got %b want 0", drop_err); end
    endtask

    task automatic test_mid_reset();
        bit seen_valid = 0;
        fill_random_row();
        pulse_conv();
        collect_row(0, 9, 3);
        n_cmp++; if (got_d.size() != 9) begin n_err++; $display("FAIL rst_pre_count: got %0d want 9", got_d.size()); end
        n_cmp++; if (ev_valid !== 1'b0 || ev_busy !== 1'b0 || ev_data !== 8'd0) begin
            n_err++; $display("FAIL rst_mid: valid %b busy %b data %0d want 0 0 0", ev_valid, ev_busy, ev_data);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) seen_valid = 1;
            tick();
        end
        n_cmp++; if (seen_valid) begin n_err++; $display("FAIL rst_residual: got valid after reset want none"); end
        fill_random_row();
        pulse_conv();
        collect_row(1, -1, 0);
        n_cmp++; if (timed_out || got_d.size() != NP) begin n_err++; $display("FAIL rst_row_count: got %0d want %0d", got_d.size(), NP); end
        for (int i = 0; i < NP && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_pix[i][7:0] || got_l[i] !== (i == NP - 1)) begin
                n_err++; $display("FAIL rst_row_pix%0d: got %0d last %b want %0d", i, got_d[i], got_l[i], exp_pix[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed_row();
        test_random_rows();
        test_backpressure();
        test_back_to_back();
        test_drop();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/relu_pool_stage.md
RELU_POOL_STAGE -- requirements
Module: relu_pool_stage

Interface
REQ-001 SHALL have parameter SHIFT, default 4, giving the requantisation right-shift amount (0..17).
REQ-002 SHALL have parameter N_IN, default 30, giving the number of conv results per row (even).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port conv_done, input, 1 bit: one-cycle pulse from the conv engine; conv_result is valid in that cycle.
REQ-006 SHALL have port conv_result, input, signed 18 bit x [0:N_IN-1]: conv engine result array.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds a valid pooled pixel.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts; a transfer occurs on an edge where out_valid and out_ready are both 1.
REQ-009 SHALL have port out_data, output, unsigned 8 bit: pooled, requantised pixel.
REQ-010 SHALL have port out_last, output, 1 bit: high with the final pixel (index N_IN/2-1) of a row.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port drop_err, output, 1 bit: sticky flag, a conv_done was dropped.

Function
REQ-013 SHALL implement states IDLE, PREP and STREAM.
REQ-014 In IDLE, an edge with conv_done=1 SHALL capture all N_IN conv_result words into an internal buffer, set index to 0 and go to PREP.
REQ-015 PREP SHALL last exactly one cycle, registering pixel 0 into out_data, setting out_valid=1 and going to STREAM. out_valid rises on the second edge after the edge that sampled conv_done.
REQ-016 Pixel i SHALL equal sat255((max(relu(buf[2i]), relu(buf[2i+1]))) >> SHIFT), where relu(x)=0 for x<0, the shift is logical, and sat255 clamps values >255 to 255.
REQ-017 In STREAM, out_data, out_last and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 On a transfer of pixel i<N_IN/2-1, the next pixel i+1 SHALL be presented on the same edge, with no bubble.
REQ-019 On the transfer with out_last=1, the block SHALL set out_valid=0 and out_last=0 and return to IDLE.
REQ-020 conv_done sampled in PREP or STREAM SHALL be ignored: the buffer is unchanged, the stream continues, and drop_err is set to 1.
REQ-021 drop_err SHALL be cleared only by rst.
REQ-022 conv_done in IDLE on the edge directly after the last transfer SHALL be accepted normally.
REQ-023 out_ready SHALL have no effect outside STREAM.

Reset
REQ-024 rst=1 at an edge SHALL force state=IDLE, index=0, out_valid=0, out_last=0, out_data=0, busy=0, drop_err=0 and buffer=0. rst takes priority over all other inputs.
REQ-025 rst mid-stream SHALL abandon the row; out_valid is 0 after that edge, and no residual pixels are emitted after rst deasserts.

Structure
REQ-026 Package npu_pkg SHALL hold constants ACC_W=18, PIX_W=8, N_CONV_OUT=30, N_POOL=15 and the typedef of the state enum.
REQ-027 The combinational per-pixel ReLU/max/shift/saturate SHALL live in one sub-module, pool_quant_lane (two ACC_W inputs, one PIX_W output, parameter SHIFT).
REQ-028 Out of the whole datapath, only out_data/out_valid/out_last SHALL be registered outputs. No combinational path SHALL exist from out_ready to out_valid.

Verification
REQ-029 Row with buf[0]=100, buf[1]=-50, rest 0, out_ready=1 -> pixel0=6 at conv_done+2 edges, then pixels 1..14=0, out_last with pixel14, busy low after.
REQ-030 buf[2]=-1, buf[3]=-200 -> pixel1=0; buf[4]=5000, buf[5]=4096 -> pixel2=255 (saturate); buf[6]=131071, buf[7]=0 -> pixel3=255.
REQ-031 out_ready low for 3 cycles while pixel7 is presented -> out_data/out_last stable for 3 cycles, no pixel lost or duplicated, exactly 15 transfers in total.
REQ-032 Second conv_done during STREAM at pixel5 -> drop_err=1 from the next edge, the row completes with the original values, and drop_err stays 1 through later rows until rst.
REQ-033 rst asserted for 1 cycle during pixel9 -> out_valid=0 and busy=0 after that edge; a new conv_done then yields a full 15-pixel row starting at pixel0.
REQ-034 Back-to-back rows with conv_done on the edge after the last transfer -> second row accepted, drop_err stays 0, and the first pixel of row 2 appears 2 edges later.
